pattern_match_ctrl: RTL and testbench
=====================================

PATTERN_MATCH_CTRL -- requirements
Module: pattern_match_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8: maximum pattern length in bits.
REQ-002 SHALL have parameter CNT_W, default 8: width of the match counter and the target.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 cfg_we  in  1  configuration write strobe.
REQ-006 cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first serial bit expected.
REQ-007 cfg_len  in  4  pattern length; legal range 1..MAX_LEN.
REQ-008 cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
REQ-009 cfg_target  in  CNT_W  match count that ends a run; 0 = unlimited.
REQ-010 start  in  1  arm-request pulse.
REQ-011 abort  in  1  abort-request pulse.
REQ-012 x_valid  in  1  qualifies x.
REQ-013 x  in  1  serial data bit.
REQ-014 busy  out  1  high in ARMED.
REQ-015 match  out  1  one-cycle pulse per detected pattern.
REQ-016 match_cnt  out  CNT_W  matches counted in the current run.
REQ-017 done  out  1  level, high in DONE.
REQ-018 cfg_err  out  1  one-cycle pulse on a rejected configuration write.

Function
REQ-019 SHALL implement three states: IDLE, ARMED, DONE.
REQ-020 Internal config registers (pattern, len, overlap, target) SHALL be written only on cfg_we in IDLE with cfg_len in 1..MAX_LEN.
REQ-021 cfg_we with an illegal cfg_len, or cfg_we in ARMED/DONE, SHALL leave the config unchanged and pulse cfg_err the next cycle.
REQ-022 start in IDLE or DONE SHALL enter ARMED and clear history, fill count, match_cnt and done.
REQ-023 When cfg_we and start are both high in IDLE, the write SHALL apply and start SHALL be ignored.
REQ-024 In ARMED, each x_valid cycle SHALL shift x into the history LSB and increment fill, saturating at MAX_LEN; x_valid low SHALL hold all state.
REQ-025 A match SHALL occur when the updated fill >= len and the updated history[len-1:0] == pattern[len-1:0].
REQ-026 match SHALL be registered and high for exactly the cycle after the accepting edge (latency 1).
REQ-027 On a match, match_cnt SHALL increment, saturating at all-ones.
REQ-028 On a match, overlap=1 SHALL retain the history and fill; overlap=0 SHALL clear fill to 0.
REQ-029 When target != 0 and the incremented match_cnt equals target, the block SHALL enter DONE on the same edge; match still pulses.
REQ-030 In DONE and IDLE, x/x_valid SHALL be ignored; match_cnt SHALL hold until the next start.
REQ-031 abort in ARMED or DONE SHALL enter IDLE.
REQ-032 abort SHALL have priority over start and over a same-cycle match: no match pulse and no count increment.
REQ-033 abort in IDLE SHALL have no effect.

Reset
REQ-034 On rst_n low, the block SHALL enter IDLE immediately, independent of clk.
REQ-035 During reset: busy=0, match=0, done=0, cfg_err=0, match_cnt=0, history=0, fill=0.
REQ-036 Reset config SHALL be pattern=4'b1010 (zero-extended), len=4, overlap=1, target=0.
REQ-037 Reset asserted mid-run SHALL discard the run with no residual match pulse.

Verification
REQ-038 Reset config, start, then stream 1,0,1,0,1,0,1 -> match pulses after bits 4 and 6; match_cnt=2; busy stays 1.
REQ-039 Write overlap=0, len=4, pattern=1010, same stream -> single match after bit 4; match_cnt=1.
REQ-040 target=2, overlap=1, stream 1,0,1,0,1,0,1,0 -> done=1 after bit 6; busy=0; later bits ignored; match_cnt=2.
REQ-041 cfg_we with cfg_len=0 or 9, and cfg_we while ARMED -> cfg_err pulses; a later 1010 stream still matches the old config.
REQ-042 abort on the same edge as a 4th matching bit -> IDLE next cycle; match stays 0; match_cnt unchanged.
REQ-043 rst_n low mid-ARMED between clock edges -> outputs reach their reset values immediately; start after reset uses the 1010 config.

Source files
------------

// File: rtl/pattern_match_ctrl.sv
// -----------------------------------------------------------------------------
// pattern_match_ctrl
//
// Serial bit-pattern detector with a small run controller. A configurable
// pattern of 1..MAX_LEN bits is compared against the most recent bits received
// on x while the block is armed. Each detection produces a one-cycle match
// pulse and bumps a saturating match counter. A non-zero target count ends
// the run automatically.
//
// Ports
//   clk          single clock, rising-edge
//   rst_n        asynchronous active-low reset
//   cfg_we       configuration write strobe (accepted only in IDLE)
//   cfg_pattern  pattern bits; bit [len-1] is the first serial bit expected
//   cfg_len      pattern length, legal 1..MAX_LEN
//   cfg_overlap  1 = overlapping detection, 0 = restart after each match
//   cfg_target   match count that ends a run; 0 = unlimited
//   start        arm request (from IDLE or DONE)
//   abort        return to IDLE (from ARMED or DONE)
//   x_valid      qualifies x
//   x            serial data bit
//   busy         high while ARMED
//   match        one-cycle pulse, the cycle after the accepting edge
//   match_cnt    matches counted in the current run
//   done         high while in DONE
//   cfg_err      one-cycle pulse after a rejected configuration write
//
// MAX_LEN must lie in 2..15 because cfg_len is four bits wide.
// -----------------------------------------------------------------------------
module pattern_match_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               abort,
  input  logic               x_valid,
  input  logic               x,
  output logic               busy,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               done,
  output logic               cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0]         LEN_MAX = 4'(MAX_LEN);
  localparam logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(4'b1010);

  // Saturating increment of the match counter.
  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    else                    return v + 1'b1;
  endfunction

  // Fill counter saturates at MAX_LEN: once the history is full it stays full.
  function automatic logic [3:0] sat_inc_fill(input logic [3:0] v);
    if (v >= LEN_MAX) return LEN_MAX;
    else              return v + 4'd1;
  endfunction

  // Mask selecting the low 'len' bits of the history / pattern.
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [3:0] len);
    logic [MAX_LEN-1:0] m;
    for (int i = 0; i < MAX_LEN; i++) m[i] = (4'(i) < len);
    return m;
  endfunction

  state_t             state_q,   state_d;
  logic [MAX_LEN-1:0] pat_q,     pat_d;
  logic [3:0]         len_q,     len_d;
  logic               ovl_q,     ovl_d;
  logic [CNT_W-1:0]   tgt_q,     tgt_d;
  logic [MAX_LEN-1:0] hist_q,    hist_d;
  logic [3:0]         fill_q,    fill_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               match_q,   match_d;
  logic               cfg_err_q, cfg_err_d;

  logic               cfg_ok;
  logic [MAX_LEN-1:0] hist_nx;
  logic [3:0]         fill_nx;
  logic [CNT_W-1:0]   cnt_inc;
  logic [MAX_LEN-1:0] mask;
  logic               hit;

  always_comb begin
    cfg_ok  = (cfg_len != 4'd0) && (cfg_len <= LEN_MAX);
    hist_nx = {hist_q[MAX_LEN-2:0], x};
    fill_nx = sat_inc_fill(fill_q);
    cnt_inc = sat_inc_cnt(cnt_q);
    mask    = len_mask(len_q);
    // Evaluated on the history/fill as they will be after this bit.
    hit     = (fill_nx >= len_q) && ((hist_nx & mask) == (pat_q & mask));
  end

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    tgt_d     = tgt_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    match_d   = 1'b0;
    cfg_err_d = 1'b0;

    if (cfg_we) begin
      if ((state_q == S_IDLE) && cfg_ok) begin
        pat_d = cfg_pattern;
        len_d = cfg_len;
        ovl_d = cfg_overlap;
        tgt_d = cfg_target;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        // A configuration write in the same cycle takes precedence over start.
        if (start && !cfg_we) begin
          state_d = S_ARMED;
          hist_d  = '0;
          fill_d  = 4'd0;
          cnt_d   = '0;
        end
      end
      S_ARMED: begin
        // Abort wins over a same-cycle match: no pulse, no count.
        if (abort) begin
          state_d = S_IDLE;
        end else if (x_valid) begin
          hist_d = hist_nx;
          fill_d = fill_nx;
          if (hit) begin
            match_d = 1'b1;
            cnt_d   = cnt_inc;
            if (!ovl_q) fill_d = 4'd0;
            if ((tgt_q != '0) && (cnt_inc == tgt_q)) state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d = S_ARMED;
          hist_d  = '0;
          fill_d  = 4'd0;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pat_q     <= RST_PAT;
      len_q     <= 4'd4;
      ovl_q     <= 1'b1;
      tgt_q     <= '0;
      hist_q    <= '0;
      fill_q    <= 4'd0;
      cnt_q     <= '0;
      match_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      tgt_q     <= tgt_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      match_q   <= match_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign busy      = (state_q == S_ARMED);
  assign done      = (state_q == S_DONE);
  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_pattern_match_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pattern_match_ctrl
//
// Directed bench for pattern_match_ctrl. A behavioural model tracks the
// expected controller state; every driven bit pushes its expected match value
// onto a queue, which is popped and compared when the DUT output is sampled.
// -----------------------------------------------------------------------------
module tb_pattern_match_ctrl;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               cfg_we = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [3:0]         cfg_len = 4'd0;
  logic               cfg_overlap = 1'b0;
  logic [CNT_W-1:0]   cfg_target = '0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic               x_valid = 1'b0;
  logic               x = 1'b0;
  logic               busy;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic               done;
  logic               cfg_err;

  pattern_match_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
    .start(start), .abort(abort), .x_valid(x_valid), .x(x),
    .busy(busy), .match(match), .match_cnt(match_cnt), .done(done),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  // Reference model: state 0 = IDLE, 1 = ARMED, 2 = DONE.
  int m_pat = 10, m_len = 4, m_ovl = 1, m_tgt = 0;
  int m_st = 0, m_hist = 0, m_fill = 0, m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pat = 10; m_len = 4; m_ovl = 1; m_tgt = 0;
    m_st = 0; m_hist = 0; m_fill = 0; m_cnt = 0;
  endtask

  task automatic send_bit(input logic b, input logic ab);
    int hit;
    int mask;
    hit = 0;
    @(negedge clk);
    x_valid = 1'b1; x = b; abort = ab;
    if (ab) begin
      if (m_st != 0) m_st = 0;
    end else if (m_st == 1) begin
      m_hist = ((m_hist << 1) | int'(b)) & ((1 << MAX_LEN) - 1);
      m_fill = (m_fill < MAX_LEN) ? m_fill + 1 : MAX_LEN;
      mask   = (1 << m_len) - 1;
      if (m_fill >= m_len && (m_hist & mask) == (m_pat & mask)) begin
        hit = 1;
        if (m_cnt < 255) m_cnt++;
        if (m_ovl == 0) m_fill = 0;
        if (m_tgt != 0 && m_cnt == m_tgt) m_st = 2;
      end
    end
    exp_q.push_back(hit);
    step();
    x_valid = 1'b0; abort = 1'b0;
    chk("match", 32'(match), exp_q.pop_front());
    chk("busy", 32'(busy), 32'(m_st == 1));
    chk("done", 32'(done), 32'(m_st == 2));
  endtask

  task automatic send_stream(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(bits[i], 1'b0);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    if (m_st != 1) begin
      m_st = 1; m_hist = 0; m_fill = 0; m_cnt = 0;
    end
    step();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'(m_st == 1));
    chk("start_cnt", 32'(match_cnt), 32'(m_cnt));
    chk("start_done", 32'(done), 0);
  endtask

  task automatic do_abort();
    @(negedge clk);
    abort = 1'b1;
    m_st = 0;
    step();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_cnt", 32'(match_cnt), 32'(m_cnt));
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len,
                        input logic ovl, input logic [7:0] tgt);
    bit ok;
    @(negedge clk);
    cfg_we = 1'b1; cfg_pattern = pat; cfg_len = len;
    cfg_overlap = ovl; cfg_target = tgt;
    ok = (m_st == 0) && (len >= 4'd1) && (len <= 4'd8);
    if (ok) begin
      m_pat = int'(pat); m_len = int'(len); m_ovl = int'(ovl); m_tgt = int'(tgt);
    end
    step();
    cfg_we = 1'b0;
    chk("cfg_err", 32'(cfg_err), 32'(!ok));
    step();
    chk("cfg_err_pulse", 32'(cfg_err), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected stopped");
    $fatal(1);
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_match", 32'(match), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    chk("rst_cnt", 32'(match_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset config, overlapping: matches after bits 4 and 6.
    do_start();
    send_stream(16'b1010101, 7);
    chk("ovl_cnt", 32'(match_cnt), 2);
    chk("ovl_busy", 32'(busy), 1);
    do_abort();

    // Non-overlapping: single match.
    do_cfg(8'b1010, 4'd4, 1'b0, 8'd0);
    do_start();
    send_stream(16'b1010101, 7);
    chk("novl_cnt", 32'(match_cnt), 1);
    do_abort();

    // Target of 2 ends the run after bit 6; later bits ignored.
    do_cfg(8'b1010, 4'd4, 1'b1, 8'd2);
    do_start();
    send_stream(16'b10101010, 8);
    chk("tgt_done", 32'(done), 1);
    chk("tgt_busy", 32'(busy), 0);
    chk("tgt_cnt", 32'(match_cnt), 2);
    do_abort();

    // Rejected writes leave the old config in place.
    do_cfg(8'hFF, 4'd0, 1'b0, 8'd0);
    do_cfg(8'hFF, 4'd9, 1'b0, 8'd0);
    do_start();
    do_cfg(8'b0110, 4'd4, 1'b0, 8'd0);
    send_stream(16'b1010, 4);
    chk("oldcfg_cnt", 32'(match_cnt), 1);
    do_abort();

    // Abort coincident with a matching bit suppresses the match.
    do_cfg(8'b1010, 4'd4, 1'b1, 8'd0);
    do_start();
    send_stream(16'b10101, 5);
    send_bit(1'b0, 1'b1);
    chk("abort_hit_cnt", 32'(match_cnt), 1);
    step();
    chk("abort_hit_match", 32'(match), 0);

    // Asynchronous reset mid-run, right while a match pulse is high.
    do_cfg(8'b0110, 4'd4, 1'b0, 8'd5);
    do_start();
    send_stream(16'b0110, 4);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_match", 32'(match), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_cnt", 32'(match_cnt), 0);
    chk("arst_cfg_err", 32'(cfg_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_start();
    send_stream(16'b1010101, 7);
    chk("post_rst_cnt", 32'(match_cnt), 2);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
